// File: rtl/btn_input_ctrl.sv
// btn_input_ctrl: push-button conditioner for the CPU side of the buttons bus.
// Each button has a 2-FF synchronizer, a debouncer, a rising-edge one-shot
// and a sticky PENDING bit. LEVEL/PENDING/MASK are visible over a small MMIO port.
// Optional feature macro: BTN_IRQ_EN (irq = registered |(PENDING & MASK)).
module btn_input_ctrl #(
    parameter int NUM_BTNS        = 5,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    input  logic [1:0]          mmio_addr,
    input  logic                mmio_rd,
    input  logic                mmio_wr,
    input  logic [31:0]         mmio_wdata,
    output logic [31:0]         mmio_rdata,
    output logic                irq
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTNS-1:0] sync1_q, sync2_q;
    logic [NUM_BTNS-1:0] level_q, level_d;
    logic [NUM_BTNS-1:0] level_dly_q;
    logic [NUM_BTNS-1:0] press_q;
    logic [NUM_BTNS-1:0] pend_q, pend_d;
    logic [NUM_BTNS-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]    cnt_q [NUM_BTNS];
    logic [CNT_W-1:0]    cnt_d [NUM_BTNS];
    logic [31:0]         rdata_q, rdata_d;
    logic                wr_pend, wr_mask;
    logic                unused_wdata;

    // Upper write-data bits beyond NUM_BTNS have no destination.
    assign unused_wdata = ^mmio_wdata;

    assign wr_pend = mmio_wr && (mmio_addr == 2'd1);
    assign wr_mask = mmio_wr && (mmio_addr == 2'd2);

    // Double-flop synchronizer for the asynchronous button pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        level_d = level_q;
        for (int unsigned i = 0; i < NUM_BTNS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state, one-shot press detection and register file update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_BTNS; i++) begin
                cnt_q[i] <= '0;
            end
            level_q     <= '0;
            level_dly_q <= '0;
            press_q     <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            rdata_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_BTNS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            rdata_q     <= rdata_d;
        end
    end

    // PENDING is W1C with set taking priority; MASK is plain read/write.
    always_comb begin
        pend_d = pend_q;
        if (wr_pend) begin
            pend_d = pend_q & ~mmio_wdata[NUM_BTNS-1:0];
        end
        pend_d = pend_d | press_q;
        mask_d = wr_mask ? mmio_wdata[NUM_BTNS-1:0] : mask_q;
    end

    // Read mux samples pre-update register values; data holds until the next read.
    always_comb begin
        rdata_d = rdata_q;
        if (mmio_rd) begin
            case (mmio_addr)
                2'd0:    rdata_d = 32'(level_q);
                2'd1:    rdata_d = 32'(pend_q);
                2'd2:    rdata_d = 32'(mask_q);
                default: rdata_d = '0;
            endcase
        end
    end

    assign btn_level  = level_q;
    assign btn_press  = press_q;
    assign mmio_rdata = rdata_q;

`ifdef BTN_IRQ_EN
    logic irq_q;

    // Level-sensitive interrupt from unmasked pending buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(pend_q & mask_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Self-checking bench for btn_input_ctrl (NUM_BTNS=5, DEBOUNCE_CYCLES=4).
module tb_btn_input_ctrl;

    localparam int NB = 5;
    localparam int DB = 4;
`ifdef BTN_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [1:0]    mmio_addr;
    logic          mmio_rd;
    logic          mmio_wr;
    logic [31:0]   mmio_wdata;
    logic [31:0]   mmio_rdata;
    logic          irq;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    btn_input_ctrl #(
        .NUM_BTNS        (NB),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .mmio_addr  (mmio_addr),
        .mmio_rd    (mmio_rd),
        .mmio_wr    (mmio_wr),
        .mmio_wdata (mmio_wdata),
        .mmio_rdata (mmio_rdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Read transaction: expected data queued at issue, popped when rdata is valid.
    task automatic do_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] e;
        mmio_addr = a;
        mmio_rd   = 1'b1;
        exp_q.push_back(exp);
        tick(1);
        mmio_rd = 1'b0;
        e = exp_q.pop_front();
        check_val(tag, mmio_rdata, e);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        mmio_addr  = a;
        mmio_wdata = d;
        mmio_wr    = 1'b1;
        tick(1);
        mmio_wr    = 1'b0;
        mmio_wdata = '0;
    endtask

    task automatic do_rdwr(input string tag, input logic [1:0] a, input logic [31:0] d,
                           input logic [31:0] exp);
        logic [31:0] e;
        mmio_addr  = a;
        mmio_wdata = d;
        mmio_wr    = 1'b1;
        mmio_rd    = 1'b1;
        exp_q.push_back(exp);
        tick(1);
        mmio_wr = 1'b0;
        mmio_rd = 1'b0;
        e = exp_q.pop_front();
        check_val(tag, mmio_rdata, e);
    endtask

    initial begin
        logic [NB-1:0] acc;
        rst_n      = 1'b0;
        btn_raw    = '0;
        mmio_addr  = '0;
        mmio_rd    = 1'b0;
        mmio_wr    = 1'b0;
        mmio_wdata = '0;

        // 1: reset holds everything at zero even with toggling inputs
        #1;
        for (int i = 0; i < 6; i++) begin
            btn_raw = (i % 2 == 0) ? 5'h1F : 5'h00;
            tick(1);
        end
        check_val("rst_level", 32'(btn_level), 32'h0);
        check_val("rst_press", 32'(btn_press), 32'h0);
        check_val("rst_rdata", mmio_rdata, 32'h0);
        check_val("rst_irq", 32'(irq), 32'h0);
        btn_raw = '0;
        tick(2);
        rst_n = 1'b1;
        tick(8);
        check_val("post_rst_level", 32'(btn_level), 32'h0);
        check_val("post_rst_irq", 32'(irq), 32'h0);
        do_read("post_rst_pend", 2'd1, 32'h0);
        do_read("post_rst_mask", 2'd2, 32'h0);

        // 2: clean press of button 4, exact latency and one-shot width
        btn_raw[4] = 1'b1;
        tick(5);
        check_val("lat_early", 32'(btn_level), 32'h0);
        tick(1);
        check_val("lat_exact", 32'(btn_level), 32'h10);
        check_val("press_not_yet", 32'(btn_press), 32'h0);
        tick(1);
        check_val("press_on", 32'(btn_press), 32'h10);
        tick(1);
        check_val("press_off", 32'(btn_press), 32'h0);
        do_read("pend_after_press", 2'd1, 32'h10);
        do_read("level_read", 2'd0, 32'h10);
        tick(2);
        check_val("rdata_hold", mmio_rdata, 32'h10);
        btn_raw[4] = 1'b0;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            acc = acc | btn_press;
        end
        check_val("fall_no_press", 32'(acc), 32'h0);
        check_val("fall_level", 32'(btn_level), 32'h0);
        do_read("fall_no_pend", 2'd1, 32'h10);
        do_write(2'd1, 32'h10);
        do_read("w1c_clear", 2'd1, 32'h0);

        // 3: short pulse is rejected
        btn_raw[0] = 1'b1;
        tick(3);
        btn_raw[0] = 1'b0;
        acc = '0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            acc = acc | btn_level | btn_press;
        end
        check_val("bounce_reject", 32'(acc), 32'h0);
        do_read("bounce_pend", 2'd1, 32'h0);

        // 4: W1C in the same cycle as the press pulse, set wins
        btn_raw[4] = 1'b1;
        tick(7);
        check_val("race_press", 32'(btn_press), 32'h10);
        do_write(2'd1, 32'h10);
        do_read("race_set_wins", 2'd1, 32'h10);
        do_write(2'd1, 32'h10);
        do_read("race_later_clear", 2'd1, 32'h0);
        btn_raw[4] = 1'b0;
        tick(8);

        // 5: async reset mid-count fully restarts the debounce
        btn_raw[2] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #2;
        check_val("async_rst_level", 32'(btn_level), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check_val("restart_early", 32'(btn_level), 32'h0);
        tick(1);
        check_val("restart_exact", 32'(btn_level), 32'h04);
        tick(1);
        check_val("restart_press", 32'(btn_press), 32'h04);
        tick(1);
        do_read("restart_pend", 2'd1, 32'h04);
        do_write(2'd1, 32'h04);
        btn_raw[2] = 1'b0;
        tick(8);

        // 6: interrupt gating by MASK
        do_write(2'd2, 32'h01);
        do_read("mask_rd", 2'd2, 32'h01);
        btn_raw[1] = 1'b1;
        tick(8);
        check_val("irq_masked_a", 32'(irq), 32'h0);
        tick(1);
        check_val("irq_masked_b", 32'(irq), 32'h0);
        btn_raw[1] = 1'b0;
        tick(8);
        do_read("pend_btn1", 2'd1, 32'h02);
        btn_raw[0] = 1'b1;
        tick(8);
        check_val("irq_set_cycle", 32'(irq), 32'h0);
        tick(1);
        check_val("irq_assert", 32'(irq), 32'(IRQ_ON));
        btn_raw[0] = 1'b0;
        tick(8);
        check_val("irq_level_hold", 32'(irq), 32'(IRQ_ON));
        do_read("pend_btn01", 2'd1, 32'h03);
        do_write(2'd1, 32'h01);
        check_val("irq_w1c_lag", 32'(irq), 32'(IRQ_ON));
        tick(1);
        check_val("irq_w1c_drop", 32'(irq), 32'h0);
        do_read("pend_after_w1c", 2'd1, 32'h02);
        do_write(2'd2, 32'h02);
        tick(1);
        check_val("irq_mask_on", 32'(irq), 32'(IRQ_ON));
        do_write(2'd2, 32'h00);
        tick(1);
        check_val("irq_mask_off", 32'(irq), 32'h0);
        do_write(2'd1, 32'hFFFF_FFFF);
        do_read("pend_all_clear", 2'd1, 32'h0);

        // 7: address decode corners, read+write collision, simultaneous presses
        do_write(2'd2, 32'h05);
        do_write(2'd0, 32'hFF);
        do_read("addr0_wr_ignored", 2'd2, 32'h05);
        do_read("addr0_level", 2'd0, 32'h0);
        do_read("addr3_zero", 2'd3, 32'h0);
        do_rdwr("rdwr_old", 2'd2, 32'hFFFF_FFFF, 32'h05);
        do_read("rdwr_new", 2'd2, 32'h1F);
        btn_raw = 5'h0A;
        tick(8);
        do_read("multi_pend", 2'd1, 32'h0A);
        do_read("multi_level", 2'd0, 32'h0A);
        btn_raw = '0;
        tick(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
